// File: rtl/step_profile_gen.sv
// Trapezoidal step-pulse generator for one stepper axis: start/busy/done handshake, symmetric
// accel/decel, graceful stop and abort. Define STEP_PROFILE_POS_EN to add a signed position output.
module step_profile_gen #(
    parameter int unsigned W       = 32,
    parameter int unsigned PULSE_W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         abort,
    input  logic         stop,
    input  logic         dir_in,
    input  logic [W-1:0] n_total,
    input  logic [W-1:0] n_acc,
    input  logic [W-1:0] t_max,
    input  logic [W-1:0] t_min,
    input  logic [W-1:0] delta,
    output logic         step,
    output logic         dir,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] steps_done
`ifdef STEP_PROFILE_POS_EN
    ,
    output logic signed [W:0] position
`endif
);
    localparam logic [W-1:0] P_FLOOR = W'(PULSE_W + 1);
    localparam logic [W-1:0] P_HIGH  = W'(PULSE_W);

    typedef enum logic {IDLE, RUN} state_t;
    state_t state;

    logic [W-1:0] n_l, na_l, tmin_l, delta_l;
    logic [W-1:0] p, acc_cnt, cnt;
    logic         stop_f;

    logic [W-1:0] tmin_e_in, tmax_e_in, cnt_nxt, sd_nxt, rem;
    logic         boundary, accel_ok;

    always_comb begin
        tmin_e_in = (t_min > P_FLOOR) ? t_min : P_FLOOR;
        tmax_e_in = (t_max > tmin_e_in) ? t_max : tmin_e_in;
        cnt_nxt   = cnt + 1'b1;
        sd_nxt    = steps_done + 1'b1;
        rem       = n_l - sd_nxt;
        boundary  = (cnt == p - 1'b1);
        // Extra bit keeps tmin+delta from wrapping; only full-delta steps are taken.
        accel_ok  = (acc_cnt < na_l) && (delta_l != '0) &&
                    ({1'b0, p} >= ({1'b0, tmin_l} + {1'b0, delta_l}));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            step       <= 1'b0;
            dir        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            steps_done <= '0;
            n_l        <= '0;
            na_l       <= '0;
            tmin_l     <= '0;
            delta_l    <= '0;
            p          <= '0;
            acc_cnt    <= '0;
            cnt        <= '0;
            stop_f     <= 1'b0;
`ifdef STEP_PROFILE_POS_EN
            position   <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (abort) begin
                state <= IDLE;
                step  <= 1'b0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            dir        <= dir_in;
                            n_l        <= n_total;
                            na_l       <= n_acc;
                            tmin_l     <= tmin_e_in;
                            delta_l    <= delta;
                            p          <= tmax_e_in;
                            acc_cnt    <= '0;
                            cnt        <= '0;
                            steps_done <= '0;
                            stop_f     <= 1'b0;
                            if (n_total == '0) begin
                                done <= 1'b1;
                            end else begin
                                state <= RUN;
                                busy  <= 1'b1;
                                step  <= 1'b1;
`ifdef STEP_PROFILE_POS_EN
                                position <= position + {{W{~dir_in}}, 1'b1};
`endif
                            end
                        end
                    end
                    RUN: begin
                        stop_f <= stop_f | stop;
                        if (!boundary) begin
                            cnt  <= cnt_nxt;
                            step <= (cnt_nxt < P_HIGH);
                        end else begin
                            cnt        <= '0;
                            steps_done <= sd_nxt;
                            if ((rem == '0) || (stop_f && (acc_cnt == '0))) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                step  <= 1'b0;
                            end else begin
                                step <= 1'b1;
`ifdef STEP_PROFILE_POS_EN
                                position <= position + {{W{~dir}}, 1'b1};
`endif
                                // Odd plateau (rem == acc_cnt+1) holds p so decel mirrors accel.
                                if (stop_f || (rem <= acc_cnt)) begin
                                    p       <= p + delta_l;
                                    acc_cnt <= acc_cnt - 1'b1;
                                end else if ((rem != acc_cnt + 1'b1) && accel_ok) begin
                                    p       <= p - delta_l;
                                    acc_cnt <= acc_cnt + 1'b1;
                                end
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
